// File: rtl/sin_table_loader_if.sv
// Stream-in and SRAM port-0 write bundle for sin_table_loader.
// The master side is the loader itself: it consumes bytes and drives the SRAM write port.
interface sin_table_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              csb0;
  logic              web0;
  logic [3:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0;

  modport master (
    input  s_valid, s_data,
    output s_ready, csb0, web0, wmask0, addr0, din0
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, csb0, web0, wmask0, addr0, din0
  );
endinterface

// File: rtl/sin_table_loader.sv
// Byte-stream loader for the sine/frequency table on SRAM port 0: packs 4 bytes per word, one write strobe per word.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module sin_table_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int FREQ_W = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [8:0]          word_count,
  sin_table_loader_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    CHK   = 3'd3,
`endif
    FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [8:0]        count_q;
  logic [8:0]        idx_q;
  logic [1:0]        bcnt_q;
  logic [DATA_W-9:0] pack_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              s_ready_q, csb0_q, web0_q, busy_q, done_q, err_q;
  logic [3:0]        wmask0_q;
  logic [ADDR_W-1:0] addr0_q;
  logic [DATA_W-1:0] din0_q;

  logic              s_ready_d, csb0_d, web0_d, busy_d, done_d, err_d;
  logic [3:0]        wmask0_d;
  logic [ADDR_W-1:0] addr0_d;
  logic [DATA_W-1:0] din0_d;

  logic hs;
  logic bad_count;
  logic last_word;

  // Only the low FREQ_W bits of a table entry are meaningful; the rest are written as zero.
  function automatic logic [DATA_W-1:0] freq_limit(input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] keep;
    keep             = '0;
    keep[FREQ_W-1:0] = '1;
    return word & keep;
  endfunction

  assign hs        = bus.s_valid & s_ready_q;
  assign bad_count = (word_count == 9'd0) || (word_count > 9'd256);
  assign last_word = ((idx_q + 9'd1) == count_q);

  // State register and load bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            idx_q   <= '0;
            bcnt_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        RECV: begin
          if (hs) begin
            bcnt_q <= bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.s_data;
`endif
          end
        end
        WRITE:   idx_q <= idx_q + 9'd1;
        default: ;
      endcase
    end
  end

  // Partial-word byte buffer; the 4th byte bypasses it straight into din0.
  always_ff @(posedge clk) begin
    if (state_q == RECV && hs) begin
      case (bcnt_q)
        2'd0:    pack_q[7:0]   <= bus.s_data;
        2'd1:    pack_q[15:8]  <= bus.s_data;
        2'd2:    pack_q[23:16] <= bus.s_data;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = bad_count ? FIN : RECV;
      RECV:  if (hs && bcnt_q == 2'd3) state_d = WRITE;
      WRITE: begin
        if (!last_word) state_d = RECV;
        else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK:   if (hs) state_d = FIN;
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    s_ready_d = (state_d == RECV);
`ifdef LOADER_CHECKSUM_EN
    if (state_d == CHK) s_ready_d = 1'b1;
`endif
    csb0_d   = (state_d != WRITE);
    web0_d   = (state_d != WRITE);
    wmask0_d = (state_d == WRITE) ? 4'hF : 4'h0;
    busy_d   = !(state_d == IDLE || state_d == FIN);
    done_d   = (state_d == FIN);
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (state_d == WRITE) begin
      addr0_d = base_q + idx_q[ADDR_W-1:0];
      din0_d  = freq_limit({bus.s_data, pack_q});
    end
    err_d = err_q;
    if (state_q == IDLE && start) err_d = bad_count;
`ifdef LOADER_CHECKSUM_EN
    if (state_q == CHK && hs && bus.s_data != csum_q) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready_q <= 1'b0;
      csb0_q    <= 1'b1;
      web0_q    <= 1'b1;
      wmask0_q  <= 4'h0;
      addr0_q   <= '0;
      din0_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s_ready_q <= s_ready_d;
      csb0_q    <= csb0_d;
      web0_q    <= web0_d;
      wmask0_q  <= wmask0_d;
      addr0_q   <= addr0_d;
      din0_q    <= din0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.csb0    = csb0_q;
  assign bus.web0    = web0_q;
  assign bus.wmask0  = wmask0_q;
  assign bus.addr0   = addr0_q;
  assign bus.din0    = din0_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sin_table_loader.sv
// Directed and randomized bench for sin_table_loader; expected SRAM writes come from a byte-level table model.
module tb_sin_table_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int FREQ_W = 20;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [8:0]        word_count = '0;
  logic              busy, done, err;

  sin_table_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sin_table_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FREQ_W(FREQ_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Observed SRAM writes and done pulses, sampled mid-cycle
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  logic [3:0]        wr_mask[$];
  int                done_cnt = 0;

  always @(negedge clk) begin
    if (!bus.csb0 && !bus.web0) begin
      wr_addr.push_back(bus.addr0);
      wr_data.push_back(bus.din0);
      wr_mask.push_back(bus.wmask0);
    end
    if (done) done_cnt++;
  end

  int        n_cmp = 0;
  int        n_bad = 0;
  bit [7:0]  stim[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table model: word w is bytes 4w..4w+3 little-endian, keeping only FREQ_W bits
  function automatic logic [DATA_W-1:0] model_word(input int w);
    longint v;
    v = longint'(stim[4*w]) + 256 * longint'(stim[4*w+1])
      + 65536 * longint'(stim[4*w+2]) + 16777216 * longint'(stim[4*w+3]);
    return DATA_W'(v % (longint'(1) << FREQ_W));
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(input int base, input int w);
    return ADDR_W'((base + w) % 256);
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  task automatic send_byte(input bit [7:0] b, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 50) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      if (bus.s_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      t++;
    end
  endtask

  task automatic run_load(input string tag, input int base, input int cnt,
                          input bit gaps, input bit poke, input bit bad_trailer);
    int       w0, d0, t;
    bit       ok;
    bit [7:0] x;
    logic     exp_err;
    w0 = wr_addr.size();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'(base); word_count = 9'(cnt);
    @(negedge clk);
    start = 1'b0; base_addr = ADDR_W'($urandom); word_count = 9'($urandom);
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_err_clr"}, err, 0);
    for (int i = 0; i < 4 * cnt; i++) begin
      if (gaps && (i % 2 == 1)) begin
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          bus.s_valid = 1'b0;
          bus.s_data  = 8'($urandom);
          start       = poke && (i == 5) && (j == 0);
        end
      end
      send_byte(stim[i], ok);
      start = 1'b0;
      chk($sformatf("%s_accept%0d", tag, i), ok, 1);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (stim[i]) if (i < 4 * cnt) x ^= stim[i];
    send_byte(x ^ {7'd0, bad_trailer}, ok);
    chk({tag, "_trailer"}, ok, 1);
    exp_err = bad_trailer;
`else
    x = 8'h00;
    exp_err = 1'b0;
`endif
    @(negedge clk);
    bus.s_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_nwrites"}, wr_addr.size() - w0, cnt);
    for (int w = 0; w < cnt && (w0 + w) < wr_addr.size(); w++) begin
      chk($sformatf("%s_addr%0d", tag, w), wr_addr[w0 + w], model_addr(base, w));
      chk($sformatf("%s_data%0d", tag, w), wr_data[w0 + w], model_word(w));
      chk($sformatf("%s_mask%0d", tag, w), wr_mask[w0 + w], 4'hF);
    end
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_strobe_idle"}, bus.csb0, 1);
  endtask

  task automatic run_illegal(input string tag, input int cnt);
    int w0, d0;
    w0 = wr_addr.size();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_W'($urandom); word_count = 9'(cnt);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_nwrites"}, wr_addr.size() - w0, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int  w0;
    bit  ok;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_csb0", bus.csb0, 1);
    chk("rst_web0", bus.web0, 1);
    chk("rst_wmask0", bus.wmask0, 4'h0);
    chk("rst_addr0", bus.addr0, 0);
    chk("rst_din0", bus.din0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;

    // Basic load with known bytes
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    w0 = wr_data.size();
    run_load("basic", 8'h10, 2, 1'b0, 1'b0, 1'b0);
    if (wr_data.size() >= w0 + 2) begin
      chk("basic_const0", wr_data[w0], 32'h0003_0201);
      chk("basic_const1", wr_data[w0 + 1], 32'h0007_0605);
    end else chk("basic_const_count", wr_data.size() - w0, 2);

    // Address wrap past FF
    fill_random(16);
    run_load("wrap", 8'hFE, 4, 1'b0, 1'b0, 1'b0);

    // Backpressure with start poked mid-load
    fill_random(8);
    run_load("bp", 8'h20, 2, 1'b1, 1'b1, 1'b0);

    // Randomized loads
    for (int k = 0; k < 4; k++) begin
      int c;
      c = int'($urandom_range(1, 6));
      fill_random(4 * c);
      run_load($sformatf("rnd%0d", k), int'($urandom_range(0, 255)), c, 1'($urandom), 1'b0, 1'b0);
    end

    // Illegal counts; err sticky until next accepted start
    run_illegal("ill0", 0);
    repeat (5) @(negedge clk);
    chk("ill0_sticky", err, 1);
    fill_random(4);
    run_load("after_ill", 8'h80, 1, 1'b0, 1'b0, 1'b0);
    run_illegal("ill300", 300);

    // Async reset clears err immediately
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk("arst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted while a write strobe is active
    fill_random(12);
    w0 = wr_addr.size();
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40; word_count = 9'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(stim[i], ok);
    #1 chk("mid_write_live", bus.csb0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_csb0", bus.csb0, 1);
    chk("mid_rst_web0", bus.web0, 1);
    chk("mid_rst_s_ready", bus.s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("mid_rst_nwrites", wr_addr.size() - w0, 0);
    chk("mid_rst_idle", busy, 0);

`ifdef LOADER_CHECKSUM_EN
    stim = '{8'hAA, 8'h55, 8'h0F, 8'hF0};
    run_load("csum_ok", 8'h30, 1, 1'b0, 1'b0, 1'b0);
    run_load("csum_bad", 8'h31, 1, 1'b0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
